// File: rtl/mod_accum_array.sv
// Multi-channel tagged accumulator with a buffered valid/ready result FIFO.
// Build option: define MOD_ACCUM_SAT_EN to saturate sums instead of wrapping them.
module mod_accum_array #(
   parameter  int NUM_CH     = 4,
   parameter  int IN_W       = 5,
   parameter  int OUT_W      = 7,
   parameter  int ACC_LEN    = 4,
   parameter  int FIFO_DEPTH = 4,
   localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [CH_W-1:0]  in_ch,
   input  logic [IN_W-1:0]  in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CH_W-1:0]  out_ch,
   output logic [OUT_W-1:0] out_data,
   output logic             out_ovf
);

   localparam int CNT_W = $clog2(ACC_LEN + 1);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int SUM_W = OUT_W + 1;

   localparam logic [CH_W:0]    NUM_CH_V = (CH_W + 1)'(NUM_CH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACC_LEN - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [PTR_W:0]   PTR_ONE  = (PTR_W + 1)'(1);

   logic [OUT_W-1:0]  acc_r [NUM_CH];
   logic [CNT_W-1:0]  cnt_r [NUM_CH];
   logic [NUM_CH-1:0] ovf_r;
   logic              run_r;

   logic [CH_W-1:0]   fifo_ch_r   [FIFO_DEPTH];
   logic [OUT_W-1:0]  fifo_data_r [FIFO_DEPTH];
   logic              fifo_ovf_r  [FIFO_DEPTH];
   logic [PTR_W:0]    wr_ptr_r;
   logic [PTR_W:0]    rd_ptr_r;

   logic              in_range_s;
   logic [OUT_W-1:0]  cur_acc_s;
   logic [CNT_W-1:0]  cur_cnt_s;
   logic              cur_ovf_s;
   logic [SUM_W-1:0]  sum_s;
   logic              new_ovf_s;
   logic [OUT_W-1:0]  new_acc_s;
   logic              last_s;
   logic              accept_s;
   logic              push_s;
   logic              pop_s;
   logic              full_s;
   logic              empty_s;

   assign full_s   = (wr_ptr_r[PTR_W] != rd_ptr_r[PTR_W]) &&
                     (wr_ptr_r[PTR_W-1:0] == rd_ptr_r[PTR_W-1:0]);
   assign empty_s  = (wr_ptr_r == rd_ptr_r);
   assign in_ready = run_r && !full_s;
   assign accept_s = in_valid && in_ready;
   assign push_s   = accept_s && in_range_s && last_s;
   assign pop_s    = out_valid && out_ready;

   // Next accumulator state for the channel addressed by the incoming sample.
   always_comb begin
      in_range_s = ({1'b0, in_ch} < NUM_CH_V);
      cur_acc_s  = '0;
      cur_cnt_s  = '0;
      cur_ovf_s  = 1'b0;
      if (in_range_s) begin
         cur_acc_s = acc_r[in_ch];
         cur_cnt_s = cnt_r[in_ch];
         cur_ovf_s = ovf_r[in_ch];
      end else begin
         cur_acc_s = '0;
         cur_cnt_s = '0;
         cur_ovf_s = 1'b0;
      end
      sum_s     = SUM_W'(cur_acc_s) + SUM_W'(in_data);
      new_ovf_s = cur_ovf_s | sum_s[OUT_W];
`ifdef MOD_ACCUM_SAT_EN
      // Once saturated, the sum is pinned at full scale until the result is emitted.
      if (new_ovf_s) begin
         new_acc_s = {OUT_W{1'b1}};
      end else begin
         new_acc_s = sum_s[OUT_W-1:0];
      end
`else
      new_acc_s = sum_s[OUT_W-1:0];
`endif
      last_s = (cur_cnt_s == LAST_CNT);
   end

   // Per-channel accumulators, sample counters and overflow flags.
   always_ff @(posedge clk) begin
      if (!reset) begin
         run_r <= 1'b0;
         ovf_r <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            acc_r[i] <= '0;
            cnt_r[i] <= '0;
         end
      end else begin
         run_r <= 1'b1;
         if (accept_s && in_range_s) begin
            if (last_s) begin
               acc_r[in_ch] <= '0;
               cnt_r[in_ch] <= '0;
               ovf_r[in_ch] <= 1'b0;
            end else begin
               acc_r[in_ch] <= new_acc_s;
               cnt_r[in_ch] <= cur_cnt_s + CNT_ONE;
               ovf_r[in_ch] <= new_ovf_s;
            end
         end
      end
   end

   // Result FIFO storage and pointers; the extra pointer MSB separates full from empty.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_ch_r[i]   <= '0;
            fifo_data_r[i] <= '0;
            fifo_ovf_r[i]  <= 1'b0;
         end
      end else begin
         if (push_s) begin
            fifo_ch_r[wr_ptr_r[PTR_W-1:0]]   <= in_ch;
            fifo_data_r[wr_ptr_r[PTR_W-1:0]] <= new_acc_s;
            fifo_ovf_r[wr_ptr_r[PTR_W-1:0]]  <= new_ovf_s;
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
      end
   end

   // Head-of-FIFO presentation, forced to zero while the FIFO is empty.
   always_comb begin
      out_valid = !empty_s;
      if (empty_s) begin
         out_ch   = '0;
         out_data = '0;
         out_ovf  = 1'b0;
      end else begin
         out_ch   = fifo_ch_r[rd_ptr_r[PTR_W-1:0]];
         out_data = fifo_data_r[rd_ptr_r[PTR_W-1:0]];
         out_ovf  = fifo_ovf_r[rd_ptr_r[PTR_W-1:0]];
      end
   end

endmodule

// File: tb/tb_mod_accum_array.sv
// Scoreboard bench for mod_accum_array: dut_a uses default parameters, dut_b uses
// NUM_CH=3/ACC_LEN=8 so overflow and out-of-range tags are reachable.
module tb_mod_accum_array;

   typedef struct packed {
      logic [1:0] ch;
      logic [6:0] data;
      logic       ovf;
   } res_t;

   logic       clk = 1'b0;
   logic       a_reset, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_ovf;
   logic [1:0] a_in_ch, a_out_ch;
   logic [4:0] a_in_data;
   logic [6:0] a_out_data;
   logic       b_reset, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_ovf;
   logic [1:0] b_in_ch, b_out_ch;
   logic [4:0] b_in_data;
   logic [6:0] b_out_data;

   int   n_checks = 0;
   int   n_fail   = 0;
   res_t exp_a[$];
   res_t exp_b[$];
   res_t ea, eb;

`ifdef MOD_ACCUM_SAT_EN
   localparam logic [6:0] OVF_SUM = 7'd127;
`else
   localparam logic [6:0] OVF_SUM = 7'd120;
`endif

   always #5 clk = ~clk;

   mod_accum_array dut_a (
      .clk(clk), .reset(a_reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
      .in_ch(a_in_ch), .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
      .out_ch(a_out_ch), .out_data(a_out_data), .out_ovf(a_out_ovf)
   );

   mod_accum_array #(.NUM_CH(3), .ACC_LEN(8)) dut_b (
      .clk(clk), .reset(b_reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .in_ch(b_in_ch), .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
      .out_ch(b_out_ch), .out_data(b_out_data), .out_ovf(b_out_ovf)
   );

   // Scoreboard for dut_a: every popped result must match the oldest expected one.
   always @(negedge clk) begin
      if (a_out_valid && a_out_ready) begin
         n_checks++;
         if (exp_a.size() == 0) begin
            n_fail++;
            $display("FAIL a_unexpected_result: got ch=%0d data=%0d ovf=%0b, required no result",
                     a_out_ch, a_out_data, a_out_ovf);
         end else begin
            ea = exp_a.pop_front();
            if ({a_out_ch, a_out_data, a_out_ovf} !== {ea.ch, ea.data, ea.ovf}) begin
               n_fail++;
               $display("FAIL a_result: got ch=%0d data=%0d ovf=%0b, required ch=%0d data=%0d ovf=%0b",
                        a_out_ch, a_out_data, a_out_ovf, ea.ch, ea.data, ea.ovf);
            end
         end
      end
   end

   // Scoreboard for dut_b.
   always @(negedge clk) begin
      if (b_out_valid && b_out_ready) begin
         n_checks++;
         if (exp_b.size() == 0) begin
            n_fail++;
            $display("FAIL b_unexpected_result: got ch=%0d data=%0d ovf=%0b, required no result",
                     b_out_ch, b_out_data, b_out_ovf);
         end else begin
            eb = exp_b.pop_front();
            if ({b_out_ch, b_out_data, b_out_ovf} !== {eb.ch, eb.data, eb.ovf}) begin
               n_fail++;
               $display("FAIL b_result: got ch=%0d data=%0d ovf=%0b, required ch=%0d data=%0d ovf=%0b",
                        b_out_ch, b_out_data, b_out_ovf, eb.ch, eb.data, eb.ovf);
            end
         end
      end
   end

   // Offer one sample to the selected DUT and hold it until the handshake completes.
   task automatic send(input bit sel, input logic [1:0] ch, input logic [4:0] d);
      int budget = 0;
      logic rdy;
      if (sel) begin
         b_in_valid = 1'b1; b_in_ch = ch; b_in_data = d;
      end else begin
         a_in_valid = 1'b1; a_in_ch = ch; a_in_data = d;
      end
      rdy = sel ? b_in_ready : a_in_ready;
      while (!rdy && budget < 60) begin
         @(posedge clk); #1;
         budget++;
         rdy = sel ? b_in_ready : a_in_ready;
      end
      if (!rdy) begin
         n_checks++;
         n_fail++;
         $display("FAIL send_timeout: in_ready=%0b after %0d cycles, required 1", rdy, budget);
      end
      @(posedge clk); #1;
      if (sel) b_in_valid = 1'b0; else a_in_valid = 1'b0;
   endtask

   task automatic check_bit(input string name, input logic got, input logic req);
      n_checks++;
      if (got !== req) begin
         n_fail++;
         $display("FAIL %s: got %0b, required %0b", name, got, req);
      end
   endtask

   task automatic wait_drain_a(input string name);
      int budget = 0;
      while (exp_a.size() != 0 && budget < 40) begin
         @(posedge clk); #1;
         budget++;
      end
      @(posedge clk); #1;
      n_checks++;
      if (exp_a.size() != 0 || a_out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL %s: pending=%0d out_valid=%0b, required pending=0 out_valid=0",
                  name, exp_a.size(), a_out_valid);
      end
   endtask

   task automatic wait_drain_b(input string name);
      int budget = 0;
      while (exp_b.size() != 0 && budget < 40) begin
         @(posedge clk); #1;
         budget++;
      end
      @(posedge clk); #1;
      n_checks++;
      if (exp_b.size() != 0 || b_out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL %s: pending=%0d out_valid=%0b, required pending=0 out_valid=0",
                  name, exp_b.size(), b_out_valid);
      end
   endtask

   task automatic test_reset();
      a_reset = 1'b0; b_reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_bit("reset_a_in_ready", a_in_ready, 1'b0);
      check_bit("reset_a_out_valid", a_out_valid, 1'b0);
      check_bit("reset_a_out_ovf", a_out_ovf, 1'b0);
      check_bit("reset_b_in_ready", b_in_ready, 1'b0);
      n_checks++;
      if (a_out_ch !== 2'd0 || a_out_data !== 7'd0) begin
         n_fail++;
         $display("FAIL reset_a_out_fields: got ch=%0d data=%0d, required 0/0", a_out_ch, a_out_data);
      end
      a_reset = 1'b1; b_reset = 1'b1;
      check_bit("release_a_in_ready_same_cycle", a_in_ready, 1'b0);
      @(posedge clk); #1;
      check_bit("release_a_in_ready", a_in_ready, 1'b1);
      check_bit("release_b_in_ready", b_in_ready, 1'b1);
   endtask

   task automatic test_single_result();
      a_out_ready = 1'b1;
      exp_a.push_back(res_t'{2'd0, 7'd12, 1'b0});
      repeat (3) send(1'b0, 2'd0, 5'd3);
      check_bit("single_no_early_valid", a_out_valid, 1'b0);
      send(1'b0, 2'd0, 5'd3);
      check_bit("single_latency_valid", a_out_valid, 1'b1);
      n_checks++;
      if (a_out_data !== 7'd12) begin
         n_fail++;
         $display("FAIL single_latency_data: got %0d, required 12", a_out_data);
      end
      wait_drain_a("single_drain");
   endtask

   task automatic test_interleave();
      a_out_ready = 1'b1;
      exp_a.push_back(res_t'{2'd0, 7'd4, 1'b0});
      exp_a.push_back(res_t'{2'd1, 7'd8, 1'b0});
      for (int i = 0; i < 4; i++) begin
         send(1'b0, 2'd0, 5'd1);
         send(1'b0, 2'd1, 5'd2);
      end
      wait_drain_a("interleave_drain");
   endtask

   task automatic test_overflow();
      b_out_ready = 1'b1;
      exp_b.push_back(res_t'{2'd2, OVF_SUM, 1'b1});
      repeat (8) send(1'b1, 2'd2, 5'd31);
      check_bit("overflow_latency_valid", b_out_valid, 1'b1);
      wait_drain_b("overflow_drain");
   endtask

   task automatic test_back_to_back_full();
      a_out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         exp_a.push_back(res_t'{2'(k), 7'(4 * (k + 1)), 1'b0});
      end
      exp_a.push_back(res_t'{2'd0, 7'd20, 1'b0});
      for (int k = 0; k < 3; k++) begin
         repeat (4) send(1'b0, 2'(k), 5'(k + 1));
      end
      repeat (3) send(1'b0, 2'd3, 5'd4);
      check_bit("full_in_ready_before_4th", a_in_ready, 1'b1);
      send(1'b0, 2'd3, 5'd4);
      check_bit("full_in_ready_after_4th", a_in_ready, 1'b0);
      fork
         repeat (4) send(1'b0, 2'd0, 5'd5);
         begin
            repeat (3) @(posedge clk);
            #1;
            check_bit("full_in_ready_held_low", a_in_ready, 1'b0);
            a_out_ready = 1'b1;
            @(posedge clk); #1;
            a_out_ready = 1'b0;
            check_bit("full_in_ready_after_pop", a_in_ready, 1'b1);
         end
      join
      check_bit("full_again_in_ready", a_in_ready, 1'b0);
      a_out_ready = 1'b1;
      wait_drain_a("full_drain");
   endtask

   task automatic test_mid_reset();
      a_out_ready = 1'b0;
      repeat (4) send(1'b0, 2'd2, 5'd7);
      repeat (2) send(1'b0, 2'd1, 5'd9);
      check_bit("midreset_queued_valid", a_out_valid, 1'b1);
      a_reset = 1'b0;
      @(posedge clk); #1;
      a_reset = 1'b1;
      check_bit("midreset_in_ready", a_in_ready, 1'b0);
      check_bit("midreset_out_valid", a_out_valid, 1'b0);
      n_checks++;
      if (a_out_data !== 7'd0) begin
         n_fail++;
         $display("FAIL midreset_out_data: got %0d, required 0", a_out_data);
      end
      a_out_ready = 1'b1;
      exp_a.push_back(res_t'{2'd1, 7'd20, 1'b0});
      repeat (4) send(1'b0, 2'd1, 5'd5);
      wait_drain_a("midreset_drain");
   endtask

   task automatic test_out_of_range();
      b_out_ready = 1'b1;
      repeat (3) send(1'b1, 2'd0, 5'd1);
      check_bit("oor_in_ready", b_in_ready, 1'b1);
      repeat (9) send(1'b1, 2'd3, 5'd31);
      repeat (2) @(posedge clk);
      #1;
      check_bit("oor_no_output", b_out_valid, 1'b0);
      exp_b.push_back(res_t'{2'd0, 7'd8, 1'b0});
      repeat (5) send(1'b1, 2'd0, 5'd1);
      wait_drain_b("oor_drain");
   endtask

   initial begin
      a_reset = 1'b0; a_in_valid = 1'b0; a_in_ch = 2'd0; a_in_data = 5'd0; a_out_ready = 1'b0;
      b_reset = 1'b0; b_in_valid = 1'b0; b_in_ch = 2'd0; b_in_data = 5'd0; b_out_ready = 1'b0;
      test_reset();
      test_single_result();
      test_interleave();
      test_back_to_back_full();
      test_mid_reset();
      test_overflow();
      test_out_of_range();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required test completion");
      $fatal(1, "watchdog expired");
   end

endmodule
